multdiv_iter: RTL and testbench
===============================

Name: multdiv_iter

Overview:
- Parametrised, multi-cycle signed multiply/divide unit for the processor's execute stage.
- Next generation of the processor's fixed 32-bit mult/div: operand width is a parameter, the handshake is defined per cycle, and the rules for restart, overflow and divide-by-zero are fixed.
- Produces a result, a one-cycle ready strobe and an exception flag that the pipeline uses to stall and to write the status register.

Parameters:
- WIDTH, 32: operand/result width in bits; legal range 4..64.
- ITER_W, $clog2(WIDTH+1): iteration counter width; derived, not overridden.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- data_operandA  in  WIDTH  multiplicand or dividend, two's complement.
- data_operandB  in  WIDTH  multiplier or divisor, two's complement.
- ctrl_MULT  in  1  single-cycle start pulse for multiply.
- ctrl_DIV  in  1  single-cycle start pulse for divide.
- data_result  out  WIDTH  product (low WIDTH bits) or quotient.
- data_exception  out  1  overflow or divide-by-zero; valid only while data_resultRDY=1.
- data_resultRDY  out  1  one-cycle strobe: result and exception valid.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0. Reset takes priority over any ctrl pulse on the same edge.
- States:
  - IDLE: waits for a start pulse.
  - MUL: radix-2 shift-add on operand magnitudes, one bit per cycle.
  - DIV: restoring division on operand magnitudes, one bit per cycle.
  - DONE: lasts one cycle; RDY=1.
  - Next state from DONE is IDLE, or MUL/DIV if a start pulse is sampled in that cycle.
- Start: operands and start pulse are sampled at edge k. Magnitudes and result sign are latched and counter=WIDTH.
- Iterations: edges k+1..k+WIDTH. At edge k+WIDTH the state becomes DONE and data_result/data_exception are registered.
- Latency: data_resultRDY is high in the cycle after edge k+WIDTH, i.e. exactly WIDTH cycles after the start edge, for exactly one cycle.
- data_result and data_exception hold their values after DONE until the next DONE or reset. data_exception is forced to 0 while RDY=0.
- Both ctrl_MULT and ctrl_DIV high on the same edge: multiply wins; the divide request is dropped.
- Start pulse while in MUL/DIV: the operation in flight is aborted with no RDY, and the new operation restarts with full latency from that edge (pipeline flush semantics).
- Multiply sign and result: sign = signA XOR signB.
  - The unit forms the 2*WIDTH-bit exact signed product.
  - data_result = low WIDTH bits of that product.
  - exception=1 if the product is outside the signed WIDTH-bit range.
- Divide: the quotient truncates toward zero.
  - Divisor = 0: result=0, exception=1. The unit still takes the full WIDTH cycles.
  - Dividend = -2^(WIDTH-1) and divisor = -1: result=0, exception=1.
- Operand ports may change after the start edge without effect.

Optional Feature:
- Macro: MULTDIV_REMAINDER_EN.
- Defined:
  - Adds output port data_remainder [WIDTH-1:0].
  - Carries the signed remainder, whose sign follows the dividend.
  - Valid with RDY on a divide. After a multiply it is 0. It is 0 on divide-by-zero and on the overflow case.
  - Registered with data_result; reset value 0.
- Undefined: the port and remainder register are absent. Quotient behaviour is identical.

Decomposition:
- Package multdiv_pkg:
  - state encoding: IDLE=2'd0, MUL=2'd1, DIV=2'd2, DONE=2'd3.
  - op encoding constants.
  - function for ITER_W.
- Sub-module multdiv_negate:
  - Parametrised WIDTH; combinational conditional two's-complement negate.
  - Instantiated for operand magnitudes and for result sign fix-up.
- The datapath and FSM stay in multdiv_iter.

Test Plan (WIDTH=32 unless noted):
- Multiply: A=7, B=-6, ctrl_MULT pulse at edge 0 -> RDY high only in cycle 32, result=-42, exception=0.
- Multiply overflow: A=0x40000000, B=4 -> result=0x00000000, exception=1. Then A=-65536, B=32768 -> result=0x80000000, exception=0.
- Divide: A=-43, B=5 -> quotient=-8, exception=0; with MULTDIV_REMAINDER_EN, data_remainder=-3.
- Divide exceptions: 10/0 -> result=0, exception=1, RDY at cycle 32. 0x80000000 / -1 -> result=0, exception=1.
- Restart and both-pulse:
  - ctrl_MULT 3*3 at edge 0, then ctrl_DIV 100/7 at edge 10 -> no RDY at cycle 32; RDY at cycle 42 with result=14.
  - ctrl_MULT and ctrl_DIV together -> multiply result returned.
- Reset and width sweep:
  - reset asserted at edge 15 of an operation -> all outputs 0 from edge 15 on, no RDY; next op has normal latency.
  - WIDTH=8: 127*-1 = -127 with no exception, RDY at cycle 8.

Source files
------------

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state/op encodings and width helper for the iterative mult/div unit
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  function automatic int iter_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/multdiv_negate.sv
// rtl/multdiv_negate.sv - conditional two's-complement negate
module multdiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - iterative signed multiply/divide, one bit per cycle
// Optional signed remainder output enabled by MULTDIV_REMAINDER_EN.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ITER_W = iter_w(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
`ifdef MULTDIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_resultRDY
);

  state_t             state, state_next;
  logic [ITER_W-1:0]  count;
  logic [2*WIDTH-1:0] p, p_next;
  logic [WIDTH-1:0]   opnd, mag_a, mag_b;
  logic               res_neg, b_zero;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;
  logic               start, start_op, last_iter;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic               mul_ovf, div_exc;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_op  = ctrl_MULT ? OP_MUL : OP_DIV;
  assign last_iter = (count == ITER_W'(1));

  multdiv_negate #(.WIDTH(WIDTH)) u_abs_a (
    .value(data_operandA), .negate(data_operandA[WIDTH-1]), .result(mag_a));
  multdiv_negate #(.WIDTH(WIDTH)) u_abs_b (
    .value(data_operandB), .negate(data_operandB[WIDTH-1]), .result(mag_b));

  // p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    div_ge    = (div_shift >= {1'b0, opnd});
    if (state == MUL) begin
      p_next = {mul_sum, p[WIDTH-1:1]};
    end else begin
      p_next = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), p[WIDTH-2:0], div_ge};
    end
  end

  multdiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value(p_next), .negate(res_neg), .result(prod));
  multdiv_negate #(.WIDTH(WIDTH)) u_fix_quot (
    .value(p_next[WIDTH-1:0]), .negate(res_neg), .result(quot));

  // A positive quotient with its top bit set can only come from MIN / -1
  assign mul_ovf = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
  assign div_exc = b_zero | (~res_neg & p_next[WIDTH-1]);

`ifdef MULTDIV_REMAINDER_EN
  logic             a_neg;
  logic [WIDTH-1:0] rem_signed, rem_q;

  multdiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .value(p_next[2*WIDTH-1:WIDTH]), .negate(a_neg), .result(rem_signed));
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (start) begin
      if (start_op == OP_MUL) state_next = MUL;
      else                    state_next = DIV;
    end else begin
      case (state)
        MUL, DIV: if (last_iter) state_next = DONE;
        DONE:     state_next = IDLE;
        default:  state_next = state;
      endcase
    end
  end

  always_comb begin
    data_resultRDY = (state == DONE);
    data_exception = exc_q & data_resultRDY;
    data_result    = result_q;
`ifdef MULTDIV_REMAINDER_EN
    data_remainder = rem_q;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      p        <= '0;
      opnd     <= '0;
      res_neg  <= 1'b0;
      b_zero   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      a_neg    <= 1'b0;
      rem_q    <= '0;
`endif
    end else if (start) begin
      count   <= ITER_W'(WIDTH);
      opnd    <= (start_op == OP_MUL) ? mag_a : mag_b;
      p       <= {{WIDTH{1'b0}}, ((start_op == OP_MUL) ? mag_b : mag_a)};
      res_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      b_zero  <= (data_operandB == '0);
`ifdef MULTDIV_REMAINDER_EN
      a_neg   <= data_operandA[WIDTH-1];
`endif
    end else if (state == MUL || state == DIV) begin
      count <= count - ITER_W'(1);
      p     <= p_next;
      if (last_iter) begin
        if (state == MUL) begin
          result_q <= prod[WIDTH-1:0];
          exc_q    <= mul_ovf;
`ifdef MULTDIV_REMAINDER_EN
          rem_q    <= '0;
`endif
        end else begin
          result_q <= div_exc ? '0 : quot;
          exc_q    <= div_exc;
`ifdef MULTDIV_REMAINDER_EN
          rem_q    <= div_exc ? '0 : rem_signed;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// tb/tb_multdiv_iter.sv - self-checking bench for multdiv_iter (32-bit and 8-bit instances)
module tb_multdiv_iter;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic [W-1:0] a, b, result;
  logic         mult, div, exc, rdy;
  logic [W8-1:0] a8, b8, result8;
  logic          mult8, div8, exc8, rdy8;
`ifdef MULTDIV_REMAINDER_EN
  logic [W-1:0]  rem;
  logic [W8-1:0] rem8;
`endif

  multdiv_iter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(a), .data_operandB(b),
    .ctrl_MULT(mult), .ctrl_DIV(div),
    .data_result(result), .data_exception(exc),
`ifdef MULTDIV_REMAINDER_EN
    .data_remainder(rem),
`endif
    .data_resultRDY(rdy));

  multdiv_iter #(.WIDTH(W8)) dut8 (
    .clock(clock), .reset(reset),
    .data_operandA(a8), .data_operandB(b8),
    .ctrl_MULT(mult8), .ctrl_DIV(div8),
    .data_result(result8), .data_exception(exc8),
`ifdef MULTDIV_REMAINDER_EN
    .data_remainder(rem8),
`endif
    .data_resultRDY(rdy8));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact signed arithmetic on 64-bit integers
  function automatic void model(input logic is_mul, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                output logic [W-1:0] e_res, output logic e_exc, output logic [W-1:0] e_rem);
    longint sa, sb, pr;
    sa = longint'($signed(op_a));
    sb = longint'($signed(op_b));
    e_rem = '0;
    if (is_mul) begin
      pr    = sa * sb;
      e_res = pr[W-1:0];
      e_exc = (pr > 64'sd2147483647) || (pr < -64'sd2147483648);
    end else if (sb == 0 || (sa == -64'sd2147483648 && sb == -1)) begin
      e_res = '0;
      e_exc = 1'b1;
    end else begin
      pr    = sa / sb;
      e_res = pr[W-1:0];
      pr    = sa % sb;
      e_rem = pr[W-1:0];
      e_exc = 1'b0;
    end
  endfunction

  task automatic run_op(input logic do_mul, input logic do_div,
                        input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        output logic [W-1:0] r_res, output logic r_exc, output logic [W-1:0] r_rem,
                        output int lat, output logic n_rdy, output logic n_exc, output logic [W-1:0] n_res);
    a = op_a; b = op_b; mult = do_mul; div = do_div;
    @(posedge clock); #1;
    mult = 1'b0; div = 1'b0;
    a = $urandom; b = $urandom;
    lat = -1; r_res = '0; r_exc = 1'b0; r_rem = '0;
    for (int c = 1; c <= W + 4; c++) begin
      @(posedge clock); #1;
      if (rdy) begin
        lat = c; r_res = result; r_exc = exc;
`ifdef MULTDIV_REMAINDER_EN
        r_rem = rem;
`endif
        break;
      end
    end
    @(posedge clock); #1;
    n_rdy = rdy; n_exc = exc; n_res = result;
  endtask

  task automatic run8(input logic do_mul, input logic [W8-1:0] op_a, input logic [W8-1:0] op_b,
                      output logic [W8-1:0] r_res, output logic r_exc, output int lat);
    a8 = op_a; b8 = op_b; mult8 = do_mul; div8 = ~do_mul;
    @(posedge clock); #1;
    mult8 = 1'b0; div8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = -1; r_res = '0; r_exc = 1'b0;
    for (int c = 1; c <= W8 + 4; c++) begin
      @(posedge clock); #1;
      if (rdy8 && lat < 0) begin
        lat = c; r_res = result8; r_exc = exc8;
      end
    end
  endtask

  typedef struct {
    logic         is_mul;
    logic [W-1:0] op_a, op_b, exp_res;
    logic         exp_exc;
    logic [W-1:0] exp_rem;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [W-1:0] r_res, r_rem, n_res, e_res, e_rem, held, res_at;
    logic         r_exc, n_rdy, n_exc, e_exc;
    logic [W8-1:0] res8;
    logic          exc8_v;
    int           lat, lat8, seen, rdy_at, bad;

    vecs[0]  = '{1'b1, 32'd7,          32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 32'h40000000,   32'd4,        32'h00000000, 1'b1, 32'd0};
    vecs[2]  = '{1'b1, 32'hFFFF0000,   32'd32768,    32'h80000000, 1'b0, 32'd0};
    vecs[3]  = '{1'b0, 32'hFFFFFFD5,   32'd5,        32'hFFFFFFF8, 1'b0, 32'hFFFFFFFD};
    vecs[4]  = '{1'b0, 32'd10,         32'd0,        32'h00000000, 1'b1, 32'd0};
    vecs[5]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1'b1, 32'd0};
    vecs[6]  = '{1'b1, 32'h80000000,   32'd1,        32'h80000000, 1'b0, 32'd0};
    vecs[7]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1, 32'd0};
    vecs[8]  = '{1'b0, 32'h80000000,   32'd1,        32'h80000000, 1'b0, 32'd0};
    vecs[9]  = '{1'b0, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32'd1};
    vecs[10] = '{1'b0, 32'd0,          32'd5,        32'h00000000, 1'b0, 32'd0};
    vecs[11] = '{1'b1, 32'h0000FFFF,   32'h0000FFFF, 32'hFFFE0001, 1'b1, 32'd0};
    vecs[12] = '{1'b0, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'h00000003, 1'b0, 32'hFFFFFFFF};

    reset = 1'b1; a = '0; b = '0; mult = 1'b0; div = 1'b0;
    a8 = '0; b8 = '0; mult8 = 1'b0; div8 = 1'b0;
    @(posedge clock); #1;
    // start pulse while reset is high must be ignored
    mult = 1'b1; a = 32'd3; b = 32'd3;
    @(posedge clock); #1;
    mult = 1'b0;
    check("reset result", result, 0);
    check("reset exception", exc, 0);
    check("reset rdy", rdy, 0);
    check("reset result8", result8, 0);
    check("reset rdy8", rdy8, 0);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < W + 3; c++) begin
      @(posedge clock); #1;
      if (rdy) seen++;
    end
    check("reset beats start pulse", seen, 0);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].is_mul, ~vecs[i].is_mul, vecs[i].op_a, vecs[i].op_b,
             r_res, r_exc, r_rem, lat, n_rdy, n_exc, n_res);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(W));
      check($sformatf("vec%0d result", i), r_res, vecs[i].exp_res);
      check($sformatf("vec%0d exception", i), r_exc, vecs[i].exp_exc);
`ifdef MULTDIV_REMAINDER_EN
      check($sformatf("vec%0d remainder", i), r_rem, vecs[i].exp_rem);
`endif
      check($sformatf("vec%0d rdy one cycle", i), n_rdy, 0);
      check($sformatf("vec%0d exception gated", i), n_exc, 0);
      check($sformatf("vec%0d result held", i), n_res, vecs[i].exp_res);
    end

    for (int i = 0; i < 60; i++) begin
      logic         m;
      logic [W-1:0] ra, rb;
      m  = 1'($urandom_range(0, 1));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = '1; end
        2: begin ra = {{20{ra[11]}}, ra[11:0]}; rb = {{28{rb[3]}}, rb[3:0]}; end
        3: begin ra = {{16{ra[15]}}, ra[15:0]}; rb = {{16{rb[15]}}, rb[15:0]}; end
        default: ;
      endcase
      model(m, ra, rb, e_res, e_exc, e_rem);
      run_op(m, ~m, ra, rb, r_res, r_exc, r_rem, lat, n_rdy, n_exc, n_res);
      check($sformatf("rand%0d latency", i), 64'(lat), 64'(W));
      check($sformatf("rand%0d result a=%h b=%h mul=%0b", i, ra, rb, m), r_res, e_res);
      check($sformatf("rand%0d exception", i), r_exc, e_exc);
`ifdef MULTDIV_REMAINDER_EN
      check($sformatf("rand%0d remainder", i), r_rem, e_rem);
`endif
    end

    // restart: 3*3 at edge 0 is flushed by 100/7 at edge 10
    a = 32'd3; b = 32'd3; mult = 1'b1;
    @(posedge clock); #1;
    mult = 1'b0;
    seen = 0; rdy_at = -1; res_at = '0;
    for (int c = 1; c <= 46; c++) begin
      if (c == 10) begin a = 32'd100; b = 32'd7; div = 1'b1; end
      @(posedge clock); #1;
      if (c == 10) div = 1'b0;
      if (rdy) begin seen++; rdy_at = c; res_at = result; end
    end
    check("restart rdy count", seen, 1);
    check("restart rdy cycle", 64'(rdy_at), 42);
    check("restart result", res_at, 14);

    run_op(1'b1, 1'b1, 32'd6, 32'hFFFFFFFD, r_res, r_exc, r_rem, lat, n_rdy, n_exc, n_res);
    check("both pulses latency", 64'(lat), 64'(W));
    check("both pulses multiply wins", r_res, 32'hFFFFFFEE);
    check("both pulses exception", r_exc, 0);

    // reset at edge 15 of an operation
    a = 32'd7; b = 32'd9; mult = 1'b1;
    @(posedge clock); #1;
    mult = 1'b0;
    bad = 0; held = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 15) reset = 1'b1;
      @(posedge clock); #1;
      if (c == 15) reset = 1'b0;
      if (c == 14) held = result;
      if (c >= 15 && (rdy || exc || result != '0)) bad++;
    end
    check("result held before reset", held, 32'hFFFFFFEE);
    check("reset mid-op outputs", bad, 0);
    run_op(1'b1, 1'b0, 32'd5, 32'd5, r_res, r_exc, r_rem, lat, n_rdy, n_exc, n_res);
    check("post-reset latency", 64'(lat), 64'(W));
    check("post-reset result", r_res, 25);

    run8(1'b1, 8'd127, 8'hFF, res8, exc8_v, lat8);
    check("w8 mul latency", 64'(lat8), 64'(W8));
    check("w8 mul result", res8, 8'h81);
    check("w8 mul exception", exc8_v, 0);
    run8(1'b0, 8'h80, 8'hFF, res8, exc8_v, lat8);
    check("w8 div ovf latency", 64'(lat8), 64'(W8));
    check("w8 div ovf result", res8, 8'h00);
    check("w8 div ovf exception", exc8_v, 1);
    run8(1'b1, 8'd16, 8'd8, res8, exc8_v, lat8);
    check("w8 mul ovf result", res8, 8'h80);
    check("w8 mul ovf exception", exc8_v, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
